// File: rtl/mips_ctrl_pkg.sv
// Shared types and constants for the multi-cycle MIPS control path:
// sequencer phases, opcode values and PC source selects.
package mips_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    ERROR  = 3'd6
  } seq_state_t;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SLI  = 3'b001;
  localparam logic [2:0] OP_J    = 3'b010;
  localparam logic [2:0] OP_JAL  = 3'b011;
  localparam logic [2:0] OP_LW   = 3'b100;
  localparam logic [2:0] OP_SW   = 3'b101;
  localparam logic [2:0] OP_BEQ  = 3'b110;
  localparam logic [2:0] OP_ADDI = 3'b111;

  localparam logic [1:0] PC_SEL_INC = 2'b00;
  localparam logic [1:0] PC_SEL_BR  = 2'b01;
  localparam logic [1:0] PC_SEL_JMP = 2'b10;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles a memory request has waited; o_expired flags the last
// cycle in which an acknowledge can still be accepted.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TMO_W       = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  logic [TMO_W-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !o_expired) begin
      r_count <= r_count + TMO_W'(1);
    end
  end

  assign o_expired = (r_count == TMO_W'(MEM_TIMEOUT));

endmodule

// File: rtl/cpu_multicycle_sequencer.sv
// Phase sequencer for the multi-cycle MIPS datapath: drives memory handshake,
// IR/PC strobes, ALU/register-write enables and counts retired instructions.
module cpu_multicycle_sequencer
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int TMO_W       = 4,
  parameter int CNT_W       = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_run_en,
  input  logic             i_halt_req,
  input  logic [2:0]       i_cpu_opcode,
  input  logic             i_branch_taken,
  input  logic             i_mem_ack,
  output logic             o_mem_req,
  output logic             o_mem_we,
  output logic             o_mem_is_ifetch,
  output logic             o_ir_load,
  output logic             o_pc_load,
  output logic [1:0]       o_pc_sel,
  output logic             o_alu_en,
  output logic             o_reg_wr_en,
  output logic             o_instr_done,
  output logic             o_busy,
  output logic             o_timeout_err,
  output logic [CNT_W-1:0] o_retired_cnt
);

  seq_state_t       r_state;
  logic [2:0]       r_opcode;
  logic             r_timeout_err;
  logic [CNT_W-1:0] r_retired_cnt;

  logic w_done;
  logic w_mem_phase;
  logic w_expired;

  assign w_mem_phase = (r_state == FETCH) || (r_state == MEM);

  // The wait count restarts whenever a request is acknowledged or no request is pending.
  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .TMO_W       (TMO_W)
  ) u_wait_timer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clear   (!w_mem_phase || i_mem_ack),
    .i_enable  (w_mem_phase && !i_mem_ack),
    .o_expired (w_expired)
  );

  always_comb begin
    o_mem_req       = 1'b0;
    o_mem_we        = 1'b0;
    o_mem_is_ifetch = 1'b0;
    o_ir_load       = 1'b0;
    o_alu_en        = 1'b0;
    o_reg_wr_en     = 1'b0;
    o_pc_sel        = PC_SEL_INC;
    w_done          = 1'b0;
    case (r_state)
      FETCH: begin
        o_mem_req       = 1'b1;
        o_mem_is_ifetch = 1'b1;
        o_ir_load       = i_mem_ack;
      end
      DECODE: begin
        if (i_cpu_opcode == OP_J) begin
          w_done   = 1'b1;
          o_pc_sel = PC_SEL_JMP;
        end
      end
      EXEC: begin
        o_alu_en = 1'b1;
        if (r_opcode == OP_BEQ) begin
          w_done   = 1'b1;
          o_pc_sel = i_branch_taken ? PC_SEL_BR : PC_SEL_INC;
        end
      end
      MEM: begin
        o_mem_req = 1'b1;
        o_mem_we  = (r_opcode == OP_SW);
        w_done    = i_mem_ack && (r_opcode == OP_SW);
      end
      WB: begin
        o_reg_wr_en = 1'b1;
        w_done      = 1'b1;
        o_pc_sel    = (r_opcode == OP_JAL) ? PC_SEL_JMP : PC_SEL_INC;
      end
      default: ;
    endcase
  end

  assign o_pc_load     = w_done;
  assign o_instr_done  = w_done;
  assign o_busy        = (r_state != IDLE) && (r_state != ERROR);
  assign o_timeout_err = r_timeout_err;
  assign o_retired_cnt = r_retired_cnt;

  // A completion cycle overrides the per-phase transition chosen above it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= IDLE;
      r_opcode      <= OP_ADD;
      r_timeout_err <= 1'b0;
      r_retired_cnt <= '0;
    end else begin
      if (w_done) begin
        r_retired_cnt <= r_retired_cnt + CNT_W'(1);
      end
      case (r_state)
        IDLE: begin
          if (i_run_en) r_state <= FETCH;
        end
        FETCH: begin
          if (i_mem_ack) begin
            r_state <= DECODE;
          end else if (w_expired) begin
            r_state       <= ERROR;
            r_timeout_err <= 1'b1;
          end
        end
        DECODE: begin
          r_opcode <= i_cpu_opcode;
          r_state  <= EXEC;
        end
        EXEC: begin
          r_state <= ((r_opcode == OP_LW) || (r_opcode == OP_SW)) ? MEM : WB;
        end
        MEM: begin
          if (i_mem_ack) begin
            r_state <= WB;
          end else if (w_expired) begin
            r_state       <= ERROR;
            r_timeout_err <= 1'b1;
          end
        end
        WB:      r_state <= IDLE;
        ERROR:   r_state <= ERROR;
        default: r_state <= IDLE;
      endcase
      if (w_done) begin
        r_state <= (i_run_en && !i_halt_req) ? FETCH : IDLE;
      end
    end
  end

endmodule

// File: tb/tb_cpu_multicycle_sequencer.sv
// Randomised self-checking bench: each instruction is expanded into its phase
// list from the opcode and memory wait counts, and every cycle is compared.
module tb_cpu_multicycle_sequencer;
  import mips_ctrl_pkg::*;

  localparam int CW = 8;
  localparam int PH_F = 1, PH_D = 2, PH_E = 3, PH_M = 4, PH_W = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          runEn, haltReq, branchTaken, memAck;
  logic [2:0]    cpuOpcode;
  logic          memReq, memWe, memIsIfetch, irLoad, pcLoad, aluEn, regWrEn;
  logic          instrDone, busy, timeoutErr;
  logic [1:0]    pcSel;
  logic [CW-1:0] retiredCnt;
  logic [10:0]   obsVec;

  int            errors = 0;
  int            checks = 0;
  logic [CW-1:0] expCnt = '0;
  logic          inFetch = 1'b0;

  always #5 clk = ~clk;

  cpu_multicycle_sequencer #(
    .MEM_TIMEOUT (15),
    .TMO_W       (4),
    .CNT_W       (CW)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_run_en        (runEn),
    .i_halt_req      (haltReq),
    .i_cpu_opcode    (cpuOpcode),
    .i_branch_taken  (branchTaken),
    .i_mem_ack       (memAck),
    .o_mem_req       (memReq),
    .o_mem_we        (memWe),
    .o_mem_is_ifetch (memIsIfetch),
    .o_ir_load       (irLoad),
    .o_pc_load       (pcLoad),
    .o_pc_sel        (pcSel),
    .o_alu_en        (aluEn),
    .o_reg_wr_en     (regWrEn),
    .o_instr_done    (instrDone),
    .o_busy          (busy),
    .o_timeout_err   (timeoutErr),
    .o_retired_cnt   (retiredCnt)
  );

  assign obsVec = {memReq, memWe, memIsIfetch, irLoad, pcLoad, pcSel,
                   aluEn, regWrEn, instrDone, busy};

  task automatic randomInputs();
    runEn       = 1'($urandom);
    haltReq     = 1'($urandom);
    cpuOpcode   = 3'($urandom);
    branchTaken = 1'($urandom);
    memAck      = 1'($urandom);
  endtask

  task automatic applyReset();
    #1 rst = 1'b1;
    #2;
    checks++;
    if (obsVec !== 11'b0 || retiredCnt !== '0 || timeoutErr !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset outputs got=%b cnt=%0d terr=%b want=0", obsVec, retiredCnt, timeoutErr);
    end
    @(posedge clk); #1;
    rst     = 1'b0;
    expCnt  = '0;
    inFetch = 1'b0;
  endtask

  task automatic idleStep(input logic goRun);
    randomInputs();
    runEn = goRun;
    @(negedge clk);
    checks++;
    if (obsVec !== 11'b0 || timeoutErr !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle outputs got=%b terr=%b want=0", obsVec, timeoutErr);
    end
    @(posedge clk); #1;
    inFetch = goRun;
  endtask

  task automatic runInstr(input logic [2:0] op, input int fWait, input int mWait,
                          input logic bt, input logic haltMid, input logic haltAtDone,
                          input logic runAfter, input string tag);
    int         ph[$];
    logic       last, lastOfKind;
    logic [1:0] doneSel;
    logic [10:0] expVec;
    if (!inFetch) idleStep(1'b1);
    for (int i = 0; i <= fWait; i++) ph.push_back(PH_F);
    ph.push_back(PH_D);
    if (op != OP_J) ph.push_back(PH_E);
    if (op == OP_LW || op == OP_SW)
      for (int i = 0; i <= mWait; i++) ph.push_back(PH_M);
    if (op inside {OP_ADD, OP_SLI, OP_ADDI, OP_JAL, OP_LW}) ph.push_back(PH_W);
    doneSel = (op == OP_J || op == OP_JAL) ? 2'b10 : ((op == OP_BEQ && bt) ? 2'b01 : 2'b00);
    for (int k = 0; k < ph.size(); k++) begin
      last       = (k == ph.size() - 1);
      lastOfKind = last || (ph[k+1] != ph[k]);
      randomInputs();
      runEn   = last ? runAfter : runEn;
      haltReq = last ? haltAtDone : (haltMid ? 1'b1 : haltReq);
      if (ph[k] == PH_D) cpuOpcode = op;
      if (ph[k] == PH_E) branchTaken = bt;
      if (ph[k] == PH_F || ph[k] == PH_M) memAck = lastOfKind;
      expVec = {(ph[k] == PH_F || ph[k] == PH_M),
                (ph[k] == PH_M && op == OP_SW),
                (ph[k] == PH_F),
                (ph[k] == PH_F && lastOfKind),
                last,
                (last ? doneSel : 2'b00),
                (ph[k] == PH_E),
                (ph[k] == PH_W),
                last,
                1'b1};
      @(negedge clk);
      checks++;
      if (obsVec !== expVec) begin
        errors++;
        $display("[TB] FAIL %s op=%0d cycle=%0d outputs got=%b want=%b", tag, op, k, obsVec, expVec);
      end
      @(posedge clk); #1;
    end
    expCnt = expCnt + CW'(1);
    checks++;
    if (retiredCnt !== expCnt) begin
      errors++;
      $display("[TB] FAIL %s retired_cnt got=%0d want=%0d", tag, retiredCnt, expCnt);
    end
    inFetch = runAfter && !haltAtDone;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    randomInputs();
    applyReset();
  endtask

  task automatic test_add();
    runInstr(OP_ADD, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, "add_zero_wait");
  endtask

  task automatic test_load_store();
    runInstr(OP_LW, 0, 2, 1'b0, 1'b0, 1'b0, 1'b1, "lw_wait2");
    runInstr(OP_SW, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, "sw");
    runInstr(OP_SW, 2, 3, 1'b1, 1'b0, 1'b0, 1'b1, "sw_waits");
  endtask

  task automatic test_branch_jump();
    runInstr(OP_BEQ, 0, 0, 1'b1, 1'b0, 1'b0, 1'b1, "beq_taken");
    runInstr(OP_BEQ, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, "beq_not_taken");
    runInstr(OP_J,   0, 0, 1'b0, 1'b0, 1'b0, 1'b1, "j");
    runInstr(OP_JAL, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, "jal");
  endtask

  task automatic test_timeout();
    if (!inFetch) idleStep(1'b1);
    for (int k = 0; k < 16; k++) begin
      randomInputs();
      memAck = 1'b0;
      @(negedge clk);
      checks++;
      if (memReq !== 1'b1 || memIsIfetch !== 1'b1 || busy !== 1'b1) begin
        errors++;
        $display("[TB] FAIL timeout_wait cycle=%0d req=%b ifetch=%b busy=%b want 1", k, memReq, memIsIfetch, busy);
      end
      @(posedge clk); #1;
    end
    for (int k = 0; k < 3; k++) begin
      randomInputs();
      @(negedge clk);
      checks++;
      if (obsVec !== 11'b0 || timeoutErr !== 1'b1) begin
        errors++;
        $display("[TB] FAIL timeout_error cycle=%0d outputs got=%b terr=%b want=0 terr=1", k, obsVec, timeoutErr);
      end
      @(posedge clk); #1;
    end
    applyReset();
    runInstr(OP_ADD, 15, 0, 1'b0, 1'b0, 1'b0, 1'b1, "fetch_ack_at_limit");
    runInstr(OP_LW, 0, 15, 1'b0, 1'b0, 1'b0, 1'b0, "mem_ack_at_limit");
    checks++;
    if (timeoutErr !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ack_at_limit timeout_err got=%b want=0", timeoutErr);
    end
  endtask

  task automatic test_halt();
    runInstr(OP_ADDI, 0, 0, 1'b0, 1'b1, 1'b0, 1'b1, "halt_mid_ignored");
    runInstr(OP_SLI, 1, 0, 1'b0, 1'b1, 1'b1, 1'b1, "halt_at_done");
    idleStep(1'b0);
  endtask

  task automatic test_random();
    logic [2:0] op;
    for (int n = 0; n < 40; n++) begin
      op = 3'($urandom);
      runInstr(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom),
               1'b0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0), "random");
    end
  endtask

  task automatic test_reset_mid_mem();
    if (!inFetch) idleStep(1'b1);
    randomInputs(); memAck = 1'b1;
    @(posedge clk); #1;
    randomInputs(); cpuOpcode = OP_SW;
    @(posedge clk); #1;
    randomInputs();
    @(posedge clk); #1;
    randomInputs(); memAck = 1'b0;
    #2;
    checks++;
    if (memReq !== 1'b1 || memWe !== 1'b1) begin
      errors++;
      $display("[TB] FAIL sw_mem_phase req=%b we=%b want 1 1", memReq, memWe);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (obsVec !== 11'b0 || retiredCnt !== '0 || timeoutErr !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset_mid_mem outputs got=%b cnt=%0d want=0", obsVec, retiredCnt);
    end
    @(posedge clk); #1;
    rst     = 1'b0;
    expCnt  = '0;
    inFetch = 1'b0;
    idleStep(1'b0);
  endtask

  task automatic test_wrap();
    while (expCnt != {CW{1'b1}})
      runInstr(OP_J, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, "wrap_fill");
    checks++;
    if (retiredCnt !== {CW{1'b1}}) begin
      errors++;
      $display("[TB] FAIL wrap_max retired_cnt got=%0d want=%0d", retiredCnt, {CW{1'b1}});
    end
    runInstr(OP_J, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, "wrap_last");
    checks++;
    if (retiredCnt !== '0) begin
      errors++;
      $display("[TB] FAIL wrap_zero retired_cnt got=%0d want=0", retiredCnt);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_load_store();
    test_branch_jump();
    test_timeout();
    test_halt();
    test_random();
    test_reset_mid_mem();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
